// File: rtl/bcd_serial_alu.sv
// Digit-serial binary/BCD adder-subtractor: one 4-bit digit per CE cycle, LSB first.
// Optional invalid-digit flag output INV when BCD_SERIAL_ALU_INVALID_EN is defined.
module bcd_serial_alu #(
  parameter int DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  CI,
  input  logic                  ADD,
  input  logic                  BCD,
  output logic [4*DIGITS-1:0]   S,
  output logic                  CO,
  output logic                  VO,
  output logic                  ZO,
  output logic                  NO,
  output logic                  BUSY,
  output logic                  DONE
`ifdef BCD_SERIAL_ALU_INVALID_EN
  ,
  output logic                  INV
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Handshake: START is accepted on a CE edge while idle; BUSY is high
  // for the RUN phase; DONE is high for exactly one CE-qualified cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_add;
  logic            r_bcd;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_s;
  logic            r_co;
  logic            r_vo;
  logic            r_zo;
  logic            r_no;

  logic [3:0]      w_a_dig;
  logic [3:0]      w_b_dig;
  logic [3:0]      w_b2;
  logic [4:0]      w_sum5;
  logic [3:0]      w_bs;
  logic            w_bc;
  logic            w_dc;
  logic [3:0]      w_digit;
  logic            w_cout;
  logic            w_vo;
  logic            w_last;
  logic [W-1:0]    w_s_next;

  assign w_last = (r_cnt == CW'(DIGITS - 1));

  always_comb begin
    w_a_dig  = 4'd0;
    w_b_dig  = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_cnt == CW'(k)) begin
        w_a_dig = r_a[4*k +: 4];
        w_b_dig = r_b[4*k +: 4];
      end
    end
  end

  always_comb begin
    w_b2    = r_add ? w_b_dig : ~w_b_dig;
    w_sum5  = {1'b0, w_a_dig} + {1'b0, w_b2} + {4'd0, r_carry};
    w_bs    = w_sum5[3:0];
    w_bc    = w_sum5[4];
    w_dc    = w_bc;
    w_digit = w_bs;
    w_cout  = w_bc;
    if (r_bcd) begin
      if (r_add) begin
        w_dc    = w_bc | (w_bs[3] & (w_bs[2] | w_bs[1]));
        w_digit = w_dc ? (w_bs + 4'd6) : w_bs;
      end else begin
        // Subtract: a missing carry means a borrow, so correct by -6 (== +10 mod 16).
        w_dc    = w_bc;
        w_digit = w_dc ? w_bs : (w_bs + 4'd10);
      end
      w_cout = w_dc;
    end
    w_vo = (~(w_a_dig[3] ^ w_b2[3])) & (w_a_dig[3] ^ w_bs[3]);
  end

  always_comb begin
    w_s_next = r_s;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_cnt == CW'(k)) begin
        w_s_next[4*k +: 4] = w_digit;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (START) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE_ST;
      DONE_ST: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_add   <= 1'b0;
      r_bcd   <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_vo    <= 1'b0;
      r_zo    <= 1'b0;
      r_no    <= 1'b0;
    end else if (CE) begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (START) begin
            r_a     <= A;
            r_b     <= B;
            r_add   <= ADD;
            r_bcd   <= BCD;
            r_carry <= CI;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_s     <= w_s_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_co <= w_cout;
            r_vo <= w_vo;
            r_zo <= (w_s_next == '0);
            r_no <= w_s_next[W-1];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_SERIAL_ALU_INVALID_EN
  logic r_inv;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_inv <= 1'b0;
    end else if (CE) begin
      if (r_state == IDLE && START) begin
        r_inv <= 1'b0;
      end else if (r_state == RUN && r_bcd &&
                   ((w_a_dig > 4'd9) || (w_b_dig > 4'd9))) begin
        r_inv <= 1'b1;
      end
    end
  end

  assign INV = r_inv;
`endif

  assign S    = r_s;
  assign CO   = r_co;
  assign VO   = r_vo;
  assign ZO   = r_zo;
  assign NO   = r_no;
  assign BUSY = (r_state == RUN);
  assign DONE = (r_state == DONE_ST);

endmodule

// File: doc/bcd_serial_alu.md
Name: bcd_serial_alu

Overview:
- Multi-digit, digit-serial binary/BCD adder-subtractor, parametrised in digit count.
- Processes one 4-bit digit per enabled clock, LSB first, carry held between digits.
- Used by the 65C816 ALU path for 8/16-bit ADC/SBC in both decimal and binary mode.
- Produces the result and the C, V, Z, N flags, with a start/busy/done handshake.

Parameters:
DIGITS, 4, number of 4-bit digits; W = 4*DIGITS; legal range 1..8.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous, active-high reset.
CE  in  1  clock enable; all state advances only on CLK edges with CE=1.
START  in  1  launch request, sampled when CE=1 and BUSY=0.
A  in  W  operand A.
B  in  W  operand B.
CI  in  1  carry in (for SBC: 1 = no borrow).
ADD  in  1  1 = add (A+B+CI), 0 = subtract (A+~B+CI).
BCD  in  1  1 = decimal correction enabled.
S  out  W  result.
CO  out  1  carry out (for subtract: 1 = no borrow).
VO  out  1  signed overflow.
ZO  out  1  1 when S == 0.
NO  out  1  S[W-1].
BUSY  out  1  operation in progress.
DONE  out  1  one-cycle pulse when the result is valid.

Behaviour:
- Reset (async, RST=1): state IDLE, S=0, CO=0, VO=0, ZO=0, NO=0, BUSY=0, DONE=0, digit counter=0.
- States:
  - IDLE: on CE & START, latch A, B, CI, ADD and BCD into operand registers; carry reg=CI; counter=0; BUSY=1; go to RUN.
  - RUN: on each CE cycle, compute digit k=counter and write S[4k+3:4k]; update the carry reg; counter+1. When k==DIGITS-1, go to DONE_ST and set CO, VO, ZO, NO.
  - DONE_ST: DONE=1 for exactly one CE-qualified cycle, BUSY=0, then return to IDLE.
- Latency: DONE asserts DIGITS+1 CE cycles after the START-accepting edge. S and flags hold stable until the next accepted START.
- Digit step (a=A digit, b=B digit, c=carry):
  - b2 = ADD ? b : ~b.
  - Binary step: {bc,bs} = a + b2 + c (5 bits).
  - BCD=0: digit = bs, carry = bc.
  - BCD=1, ADD=1: dc = bc | (bs[3]&(bs[2]|bs[1])); digit = dc ? bs+6 (mod 16) : bs; carry = dc.
  - BCD=1, ADD=0: dc = bc; digit = dc ? bs : bs+10 (mod 16), i.e. minus 6; carry = dc.
- Flags:
  - VO is taken from the top digit only, before correction: (~(a[3]^b2[3])) & (a[3]^bs[3]).
  - CO = final carry reg.
  - ZO and NO are evaluated on the final corrected S.
- Invalid BCD digits (>9) in BCD mode produce the deterministic result of the formulas above. No error is raised unless the optional feature is enabled.
- START while BUSY or in DONE_ST is ignored; no queuing.
- Input changes after acceptance have no effect; operands are registered.
- CE=0 freezes all state, including DONE: the pulse stretches until the next CE cycle.
- RST mid-operation aborts immediately to the reset values; no DONE is produced.
- DIGITS=1: RUN lasts one cycle.

Optional Feature:
- Macro: BCD_SERIAL_ALU_INVALID_EN.
- When defined:
  - Extra output port INV (1 bit), reset 0.
  - INV is cleared on an accepted START.
  - INV is set in RUN when BCD=1 and either the a digit or the b digit of the current step is >9.
  - INV is valid with DONE and held afterwards.
- When undefined: no INV port and no invalid-digit logic.

Test Plan:
- DIGITS=4, BCD add, A=0x0999, B=0x0001, CI=0 -> after 5 CE cycles: S=0x1000, CO=0, ZO=0, NO=0, DONE pulse of 1 cycle.
- BCD subtract, A=0x0000, B=0x0001, CI=1 -> S=0x9999, CO=0, NO=1. Also A=0x1000, B=0x0001, CI=1 -> S=0x0999, CO=1.
- Binary add, A=0x7FFF, B=0x0001, CI=0 -> S=0x8000, VO=1, NO=1, CO=0. Binary add, A=0xFFFF, B=0x0001 -> S=0x0000, CO=1, ZO=1, VO=0.
- CE toggled 1,0,1,0 during RUN on the BCD add 0x0999+0x0001 case -> result identical to the uninterrupted run; latency counted only over CE=1 cycles. START pulsed during BUSY -> ignored, result unchanged.
- RST asserted during the second RUN digit -> outputs at reset values asynchronously, no DONE. A new START after release completes normally.
- With BCD_SERIAL_ALU_INVALID_EN: BCD add, A=0x000A, B=0x0001 -> INV=1 at DONE. BCD add, A=0x0009, B=0x0001 -> INV=0, S=0x0010.
